// File: rtl/sonar_sweep_scheduler.sv
// Sweep scheduler for the sonar servo.
// Steps the position index back and forth across POSICOES positions. At each
// position it waits T_ASSENT settle cycles, fires one measure/transmit start
// pulse, then waits for the control unit to report the cycle done.
// Supports continuous sweeping (modo=0) or a single end-to-end sweep (modo=1).
//
// Optional macro SONAR_TIMEOUT_EN: when defined, AGUARDA is bounded by
// T_TIMEOUT cycles and a missing ciclo_pronto raises erro (state ERRO).
// When undefined, AGUARDA waits indefinitely and erro is tied low.
//
// state     | meaning
// ----------+---------------------------------------------------------
// PARADO    | idle, waiting for ligar
// POSICIONA | servo commanded to posicao, settle timer cleared
// ASSENTA   | settling for T_ASSENT cycles
// DISPARA   | one-cycle start pulse to the sonar control unit
// AGUARDA   | waiting for ciclo_pronto
// AVANCA    | step posicao; flags endpoint, may turn around or stop
// FIM       | single sweep finished, holds until ligar drops
// ERRO      | ciclo_pronto timeout (only with SONAR_TIMEOUT_EN)

module sonar_sweep_scheduler #(
    parameter int POSICOES  = 8,
    parameter int T_ASSENT  = 25000000,
    parameter int T_TIMEOUT = 50000000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ligar,
    input  logic                        modo,
    input  logic                        ciclo_pronto,
    output logic                        iniciar_ciclo,
    output logic [$clog2(POSICOES)-1:0] posicao,
    output logic                        sentido,
    output logic                        fim_varredura,
    output logic                        ocupado,
    output logic                        erro,
    output logic [3:0]                  db_estado
);

    localparam int PW    = $clog2(POSICOES);
    localparam int T_MAX = (T_ASSENT > T_TIMEOUT) ? T_ASSENT : T_TIMEOUT;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [PW-1:0] POS_ULT    = PW'(POSICOES - 1);
    localparam logic [TW-1:0] ASSENT_FIM = TW'(T_ASSENT - 1);
`ifdef SONAR_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_FIM = TW'(T_TIMEOUT - 1);
`endif

    typedef enum logic [3:0] {
        PARADO    = 4'h0,
        POSICIONA = 4'h1,
        ASSENTA   = 4'h2,
        DISPARA   = 4'h3,
        AGUARDA   = 4'h4,
        AVANCA    = 4'h5,
        ERRO      = 4'hE,
        FIM       = 4'hF
    } estado_t;

    estado_t        r_estado;
    estado_t        w_prox;
    logic [TW-1:0]  r_timer;
    logic [PW-1:0]  r_posicao;
    logic           r_sentido;
    logic           w_extremo;
    logic           w_sobe;

    // Endpoint: moving up at the last index, or moving down at index 0.
    assign w_extremo = (r_sentido && (r_posicao == POS_ULT)) ||
                       (!r_sentido && (r_posicao == '0));
    // Direction of the next step; turns around at an endpoint.
    assign w_sobe    = r_sentido ^ w_extremo;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= PARADO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state logic; ligar low overrides every other transition.
    always_comb begin
        w_prox = r_estado;
        if (!ligar) begin
            w_prox = PARADO;
        end else begin
            case (r_estado)
                PARADO:    w_prox = POSICIONA;
                POSICIONA: w_prox = ASSENTA;
                ASSENTA:   if (r_timer == ASSENT_FIM) w_prox = DISPARA;
                DISPARA:   w_prox = AGUARDA;
                AGUARDA: begin
                    if (ciclo_pronto) begin
                        w_prox = AVANCA;
                    end
`ifdef SONAR_TIMEOUT_EN
                    else if (r_timer == TIMEOUT_FIM) begin
                        w_prox = ERRO;
                    end
`endif
                end
                AVANCA:    w_prox = (w_extremo && modo) ? FIM : POSICIONA;
                FIM:       w_prox = FIM;
                ERRO:      w_prox = ERRO;
                default:   w_prox = PARADO;
            endcase
        end
    end

    // Shared timer: settle count in ASSENTA, timeout count in AGUARDA.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else begin
            case (r_estado)
                ASSENTA: r_timer <= r_timer + TW'(1);
`ifdef SONAR_TIMEOUT_EN
                AGUARDA: r_timer <= r_timer + TW'(1);
`else
                AGUARDA: r_timer <= r_timer;
`endif
                default: r_timer <= '0;
            endcase
        end
    end

    // Position and direction: restart at 0 going up, step in AVANCA.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_posicao <= '0;
            r_sentido <= 1'b1;
        end else if (ligar) begin
            if (r_estado == PARADO) begin
                r_posicao <= '0;
                r_sentido <= 1'b1;
            end else if (r_estado == AVANCA) begin
                r_posicao <= w_sobe ? (r_posicao + PW'(1)) : (r_posicao - PW'(1));
                r_sentido <= w_sobe;
            end
        end
    end

    assign posicao       = r_posicao;
    assign sentido       = r_sentido;
    assign iniciar_ciclo = (r_estado == DISPARA);
    assign fim_varredura = (r_estado == AVANCA) && w_extremo;
    assign ocupado       = (r_estado != PARADO);
    assign db_estado     = r_estado;
`ifdef SONAR_TIMEOUT_EN
    assign erro          = (r_estado == ERRO);
`else
    assign erro          = 1'b0;
`endif

endmodule

// File: tb/tb_sonar_sweep_scheduler.sv
// Bench for sonar_sweep_scheduler (POSICOES=4, T_ASSENT=5, T_TIMEOUT=20).
// A behavioural model derives position/direction from the step count of the
// sweep (triangle wave) and the phase from a cycle count within a position.
// Directed scenarios pin the model with literal expectations, then random
// stimulus runs against the model.

module tb_sonar_sweep_scheduler;

    localparam int P  = 4;
    localparam int TA = 5;
    localparam int TT = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       modo;
    logic       ciclo_pronto;
    logic       iniciar_ciclo;
    logic [1:0] posicao;
    logic       sentido;
    logic       fim_varredura;
    logic       ocupado;
    logic       erro;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_pos[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int exp_sen[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    int exp_fim[8] = '{0, 0, 0, 1, 0, 0, 1, 0};

    sonar_sweep_scheduler #(
        .POSICOES  (P),
        .T_ASSENT  (TA),
        .T_TIMEOUT (TT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .modo          (modo),
        .ciclo_pronto  (ciclo_pronto),
        .iniciar_ciclo (iniciar_ciclo),
        .posicao       (posicao),
        .sentido       (sentido),
        .fim_varredura (fim_varredura),
        .ocupado       (ocupado),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 running, 2 single sweep done, 3 timeout error
    int m_mode, m_ph, m_tw, m_n, m_pos;
    bit m_wait, m_adv, m_sent;

    // Index at step n of a sweep starting at 0: triangle wave of period 2(P-1).
    function automatic int pos_at(int n);
        int m = n % (2 * P - 2);
        return (m <= P - 1) ? m : (2 * P - 2 - m);
    endfunction

    // Direction held while at step n (the turnaround happens when leaving).
    function automatic bit dir_at(int n);
        int m = n % (2 * P - 2);
        if (n == 0) return 1'b1;
        return (m >= 1) && (m <= P - 1);
    endfunction

    function automatic bit endpoint(int n);
        int m = n % (2 * P - 2);
        return ((n > 0) && (m == 0)) || (m == P - 1);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_pos <= 0; m_sent <= 1'b1; m_ph <= 0; m_tw <= 0;
            m_n <= 0; m_wait <= 1'b0; m_adv <= 1'b0;
        end else if (!ligar) begin
            m_mode <= 0;
        end else begin
            case (m_mode)
                0: begin
                    m_mode <= 1; m_n <= 0; m_ph <= 0; m_wait <= 1'b0; m_adv <= 1'b0;
                    m_pos <= 0; m_sent <= 1'b1;
                end
                1: begin
                    if (m_adv) begin
                        if (endpoint(m_n) && modo) m_mode <= 2;
                        m_n    <= m_n + 1;
                        m_pos  <= pos_at(m_n + 1);
                        m_sent <= dir_at(m_n + 1);
                        m_adv  <= 1'b0;
                        m_ph   <= 0;
                    end else if (m_wait) begin
                        if (ciclo_pronto) begin
                            m_wait <= 1'b0;
                            m_adv  <= 1'b1;
                        end
`ifdef SONAR_TIMEOUT_EN
                        else if (m_tw == TT - 1) begin
                            m_mode <= 3;
                        end
`endif
                        else begin
                            m_tw <= m_tw + 1;
                        end
                    end else if (m_ph == TA + 1) begin
                        m_wait <= 1'b1;
                        m_tw   <= 0;
                    end else begin
                        m_ph <= m_ph + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        int e_db, e_ini, e_fim, e_err;
        if (!reset) begin
            if (m_mode == 0)      e_db = 0;
            else if (m_mode == 2) e_db = 15;
            else if (m_mode == 3) e_db = 14;
            else if (m_adv)       e_db = 5;
            else if (m_wait)      e_db = 4;
            else if (m_ph == 0)   e_db = 1;
            else if (m_ph <= TA)  e_db = 2;
            else                  e_db = 3;
            e_ini = (m_mode == 1 && !m_adv && !m_wait && m_ph == TA + 1) ? 1 : 0;
            e_fim = (m_mode == 1 && m_adv && endpoint(m_n)) ? 1 : 0;
            e_err = (m_mode == 3) ? 1 : 0;
            check("m_db_estado", int'(db_estado), e_db);
            check("m_iniciar", int'(iniciar_ciclo), e_ini);
            check("m_fim", int'(fim_varredura), e_fim);
            check("m_posicao", int'(posicao), m_pos);
            check("m_sentido", int'(sentido), int'(m_sent));
            check("m_ocupado", int'(ocupado), (m_mode != 0) ? 1 : 0);
            check("m_erro", int'(erro), e_err);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_db(input int code, input int budget, input string nm);
        int i = 0;
        while (int'(db_estado) != code && i < budget) begin
            tick();
            i++;
        end
        check(nm, int'(db_estado), code);
    endtask

    // Wait for DISPARA, answer ciclo_pronto 3 cycles later, land in AVANCA.
    task automatic serve(output logic [1:0] p, output logic s, output logic f);
        wait_db(3, 200, "wait_dispara");
        p = posicao;
        s = sentido;
        tick();
        check("iniciar_width", int'(iniciar_ciclo), 0);
        repeat (2) tick();
        ciclo_pronto = 1'b1;
        tick();
        f = fim_varredura;
        ciclo_pronto = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] p;
        logic       s, f;
        int         cnt;

        reset = 1'b1; ligar = 1'b0; modo = 1'b0; ciclo_pronto = 1'b0;
        repeat (3) tick();
        check("rst_posicao", int'(posicao), 0);
        check("rst_sentido", int'(sentido), 1);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_db", int'(db_estado), 0);
        check("rst_iniciar", int'(iniciar_ciclo), 0);
        check("rst_erro", int'(erro), 0);
        reset = 1'b0;
        tick();

        // Start latency: iniciar_ciclo on the 7th cycle after ligar is sampled.
        ligar = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("lat_iniciar", int'(iniciar_ciclo), (i == 7) ? 1 : 0);
        end
        check("lat_posicao", int'(posicao), 0);
        check("lat_ocupado", int'(ocupado), 1);

        // Continuous sweep sequence.
        for (int k = 0; k < 8; k++) begin
            serve(p, s, f);
            check("seq_posicao", int'(p), exp_pos[k]);
            check("seq_sentido", int'(s), exp_sen[k]);
            check("seq_fim", int'(f), exp_fim[k]);
        end

        // Single sweep: stops in FIM at posicao 2.
        ligar = 1'b0;
        repeat (2) tick();
        modo = 1'b1;
        ligar = 1'b1;
        for (int k = 0; k < 4; k++) begin
            serve(p, s, f);
            check("single_posicao", int'(p), k);
            check("single_fim", int'(f), (k == 3) ? 1 : 0);
        end
        tick();
        check("fim_db", int'(db_estado), 15);
        check("fim_posicao", int'(posicao), 2);
        check("fim_sentido", int'(sentido), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (iniciar_ciclo) cnt++;
        end
        check("fim_no_iniciar", cnt, 0);
        check("fim_hold_db", int'(db_estado), 15);
        ligar = 1'b0;
        tick();
        ligar = 1'b1;
        modo = 1'b0;
        serve(p, s, f);
        check("restart_posicao", int'(p), 0);

        // ligar dropped while settling at posicao 2.
        serve(p, s, f);
        check("drop_pre_posicao", int'(p), 1);
        wait_db(2, 50, "drop_wait_assenta");
        check("drop_assenta_pos", int'(posicao), 2);
        ligar = 1'b0;
        tick();
        check("drop_ocupado", int'(ocupado), 0);
        check("drop_db", int'(db_estado), 0);
        check("drop_posicao", int'(posicao), 2);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (iniciar_ciclo) cnt++;
        end
        check("drop_no_iniciar", cnt, 0);
        ligar = 1'b1;
        serve(p, s, f);
        check("drop_restart_pos", int'(p), 0);

        // ciclo_pronto outside AGUARDA is ignored.
        wait_db(2, 50, "ign_wait_assenta");
        ciclo_pronto = 1'b1;
        tick();
        ciclo_pronto = 1'b0;
        wait_db(3, 50, "ign_wait_dispara");
        ciclo_pronto = 1'b1;
        tick();
        ciclo_pronto = 1'b0;
        check("ign_in_aguarda", int'(db_estado), 4);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int'(db_estado) != 4) cnt++;
        end
        check("ign_stays", cnt, 0);
        ciclo_pronto = 1'b1;
        tick();
        ciclo_pronto = 1'b0;
        check("ign_avanca", int'(db_estado), 5);
        check("ign_posicao", int'(posicao), 1);

        // Timeout behaviour.
        wait_db(3, 50, "to_wait_dispara");
        tick();
`ifdef SONAR_TIMEOUT_EN
        cnt = 0;
        while (int'(db_estado) == 4 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("to_cycles", cnt, TT);
        check("to_db", int'(db_estado), 14);
        check("to_erro", int'(erro), 1);
        ligar = 1'b0;
        tick();
        check("to_clear_erro", int'(erro), 0);
        check("to_clear_db", int'(db_estado), 0);
`else
        repeat (100) tick();
        check("noto_db", int'(db_estado), 4);
        check("noto_erro", int'(erro), 0);
        ligar = 1'b0;
        tick();
        check("noto_drop_db", int'(db_estado), 0);
`endif
        ligar = 1'b1;

        // Random stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            ligar = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) == 0) modo = ~modo;
            ciclo_pronto = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
            reset = (c == 2000) ? 1'b1 : 1'b0;
            tick();
        end
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
